// File: rtl/shift_iter_pkg.sv
// Shared definitions for the iterative shifter: opcodes and FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package shift_iter_pkg;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage.sv
// Single power-of-two shift stage: shifts i_data by the one-hot distance i_dist when enabled.
// Latency: combinational.
// Backpressure: none.
// Ports: i_data (operand), i_op (SLL/SRA), i_dist (one-hot 2^k distance),
//        i_enable (apply the shift), o_data (shifted or passed-through value).
module shift_stage
  import shift_iter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIST_W = 5
) (
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_op,
  input  logic [DIST_W-1:0] i_dist,
  input  logic              i_enable,
  output logic [WIDTH-1:0]  o_data
);

  // The distance is always a single power of two, so each candidate is a
  // constant shift and the whole stage reduces to an AND-OR select rather
  // than a variable barrel.
  always_comb begin
    o_data = i_data;
    if (i_enable) begin
      for (int s = 0; s < DIST_W; s++) begin
        if (i_dist == DIST_W'(1 << s)) begin
          // Separate assignments keep the SRA operand signed; mixing it with
          // the unsigned SLL term in one ternary would make it logical.
          if (i_op == OP_SRA) begin
            o_data = $signed(i_data) >>> (1 << s);
          end else begin
            o_data = i_data << (1 << s);
          end
        end
      end
    end
  end

endmodule

// File: rtl/shift_iter.sv
// Multi-cycle SLL/SRA unit iterating one power-of-two stage per clock.
// Latency: fixed SHAMT_W+1 edges from accept to the data_resultRDY cycle, for any amount.
// Backpressure: none; ctrl_start is ignored while ctrl_busy, accepted in IDLE or DONE.
// Ports: clock/reset (sync, active-high); ctrl_start/ctrl_op/data_operandA/ctrl_shiftamt
//        sampled at accept; data_result held until next completion; data_resultRDY
//        one-cycle pulse; ctrl_busy high during the shift iterations.
// Requires 2**SHAMT_W <= WIDTH.
module shift_iter
  import shift_iter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic               ctrl_op,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               ctrl_busy
);

  localparam int KW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SHAMT_W - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_result;
  logic [SHAMT_W-1:0] r_amt;
  logic               r_op;
  logic [KW-1:0]      r_k;

  logic               w_accept;
  logic               w_last;
  logic               w_stage_en;
  logic [SHAMT_W-1:0] w_dist;
  logic [WIDTH-1:0]   w_stage_out;

  // DONE accepts like IDLE so back-to-back operations need no bubble.
  assign w_accept   = ctrl_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last     = (r_state == ST_SHIFT) && (r_k == K_LAST);
  assign w_stage_en = r_amt[r_k];
  assign w_dist     = SHAMT_W'(1) << r_k;

  shift_stage #(
    .WIDTH (WIDTH),
    .DIST_W(SHAMT_W)
  ) u_stage (
    .i_data  (r_acc),
    .i_op    (r_op),
    .i_dist  (w_dist),
    .i_enable(w_stage_en),
    .o_data  (w_stage_out)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (ctrl_start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ctrl_start ? ST_SHIFT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    data_resultRDY = (r_state == ST_DONE);
    ctrl_busy      = (r_state == ST_SHIFT);
  end

  assign data_result = r_result;

  // Datapath: operand capture, per-stage accumulate, result capture on the last stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc    <= '0;
      r_amt    <= '0;
      r_op     <= OP_SLL;
      r_k      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_acc <= data_operandA;
      r_amt <= ctrl_shiftamt;
      r_op  <= ctrl_op;
      r_k   <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_acc <= w_stage_out;
      r_k   <= w_last ? '0 : r_k + KW'(1);
      if (w_last) begin
        r_result <= w_stage_out;
      end
    end
  end

endmodule

// File: tb/tb_shift_iter.sv
module tb_shift_iter;

  logic        clock;
  logic        reset;
  logic        ctrl_start;
  logic        ctrl_op;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        ctrl_busy;

  int checks = 0;
  int errors = 0;

  shift_iter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_start    (ctrl_start),
    .ctrl_op       (ctrl_op),
    .data_operandA (data_operandA),
    .ctrl_shiftamt (ctrl_shiftamt),
    .data_result   (data_result),
    .data_resultRDY(data_resultRDY),
    .ctrl_busy     (ctrl_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // All driving and sampling happens 1ns after a rising edge ("cycle" phase).
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called in cycle 0; returns in cycle 1 with ctrl_start released.
  task automatic issue(input logic op, input logic [31:0] a, input logic [4:0] amt);
    ctrl_start    = 1'b1;
    ctrl_op       = op;
    data_operandA = a;
    ctrl_shiftamt = amt;
    step();
    ctrl_start    = 1'b0;
    data_operandA = 32'h0BAD_F00D;
    ctrl_shiftamt = 5'd7;
  endtask

  // Watches from cycle 'first' for RDY (bounded); reports the cycle it was seen
  // (-1 on timeout), the result then, and how many cycles showed busy before it.
  task automatic wait_rdy(input int first, output int cyc, output logic [31:0] res,
                          output int busy_cnt);
    cyc      = -1;
    res      = 'x;
    busy_cnt = 0;
    for (int c = first; c < first + 20; c++) begin
      if (data_resultRDY === 1'b1) begin
        cyc = c;
        res = data_result;
        break;
      end
      if (ctrl_busy === 1'b1) busy_cnt++;
      step();
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    ctrl_start = 1'b1;
    ctrl_op    = 1'b0;
    data_operandA = 32'hFFFF_FFFF;
    ctrl_shiftamt = 5'd1;
    step();
    step();
    checks++;
    if (data_result !== 32'h0) begin
      errors++; $display("FAIL reset_result: got %h want 00000000", data_result);
    end
    checks++;
    if (data_resultRDY !== 1'b0) begin
      errors++; $display("FAIL reset_rdy: got %b want 0", data_resultRDY);
    end
    checks++;
    if (ctrl_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", ctrl_busy);
    end
    ctrl_start = 1'b0;
    reset      = 1'b0;
    step();
    checks++;
    if (ctrl_busy !== 1'b0 || data_resultRDY !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy %b rdy %b want 0 0", ctrl_busy, data_resultRDY);
    end
  endtask

  task automatic test_basic_latency();
    int cyc, busy_cnt;
    logic [31:0] res;
    issue(1'b0, 32'h0000_0001, 5'd2);
    wait_rdy(1, cyc, res, busy_cnt);
    checks++;
    if (cyc != 6) begin errors++; $display("FAIL basic_rdy_cycle: got %0d want 6", cyc); end
    checks++;
    if (busy_cnt != 5) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 5", busy_cnt); end
    checks++;
    if (res !== 32'h0000_0004) begin errors++; $display("FAIL basic_result: got %h want 00000004", res); end
    checks++;
    if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b want 0", ctrl_busy); end
    step();
    checks++;
    if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL basic_rdy_pulse: got %b want 0", data_resultRDY); end
    step();
    checks++;
    if (data_result !== 32'h0000_0004) begin
      errors++; $display("FAIL basic_hold: got %h want 00000004", data_result);
    end
  endtask

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [4:0]  amt;
    logic [31:0] exp;
  } vec_t;

  task automatic test_vectors();
    vec_t v[14];
    int cyc, busy_cnt;
    logic [31:0] res;
    v[0]  = '{1'b0, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    v[1]  = '{1'b1, 32'h8000_0000, 5'd4,  32'hF800_0000};
    v[2]  = '{1'b1, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF};
    v[3]  = '{1'b0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    v[4]  = '{1'b1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    v[5]  = '{1'b0, 32'hFFFF_FFFE, 5'd31, 32'h0000_0000};
    v[6]  = '{1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    v[7]  = '{1'b1, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    v[8]  = '{1'b0, 32'hA5A5_A5A5, 5'd8,  32'hA5A5_A500};
    v[9]  = '{1'b1, 32'h1234_5678, 5'd16, 32'h0000_1234};
    v[10] = '{1'b0, 32'h1234_5678, 5'd16, 32'h5678_0000};
    v[11] = '{1'b1, 32'hF000_0000, 5'd3,  32'hFE00_0000};
    v[12] = '{1'b0, 32'h8000_0001, 5'd1,  32'h0000_0002};
    v[13] = '{1'b1, 32'h8765_4321, 5'd12, 32'hFFF8_7654};
    for (int i = 0; i < 14; i++) begin
      issue(v[i].op, v[i].a, v[i].amt);
      wait_rdy(1, cyc, res, busy_cnt);
      checks++;
      if (cyc != 6) begin errors++; $display("FAIL vec%0d_rdy_cycle: got %0d want 6", i, cyc); end
      checks++;
      if (res !== v[i].exp) begin
        errors++; $display("FAIL vec%0d_result: got %h want %h", i, res, v[i].exp);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int cyc, busy_cnt;
    logic [31:0] res;
    issue(1'b0, 32'h0000_0001, 5'd1);   // now cycle 1
    step();                              // cycle 2: start while busy must be ignored
    ctrl_start    = 1'b1;
    ctrl_op       = 1'b0;
    data_operandA = 32'h0000_0001;
    ctrl_shiftamt = 5'd3;
    step();
    ctrl_start = 1'b0;
    wait_rdy(3, cyc, res, busy_cnt);
    checks++;
    if (cyc != 6) begin errors++; $display("FAIL ignore_rdy_cycle: got %0d want 6", cyc); end
    checks++;
    if (res !== 32'h0000_0002) begin errors++; $display("FAIL ignore_result: got %h want 00000002", res); end
    // Issue in the DONE cycle: accepted without a bubble.
    issue(1'b1, 32'hFFFF_FF00, 5'd8);
    wait_rdy(1, cyc, res, busy_cnt);
    checks++;
    if (cyc != 6) begin errors++; $display("FAIL b2b_rdy_cycle: got %0d want 6", cyc); end
    checks++;
    if (busy_cnt != 5) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 5", busy_cnt); end
    checks++;
    if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_result: got %h want ffffffff", res); end
    step();
  endtask

  task automatic test_reset_mid_shift();
    int cyc, busy_cnt, rdy_seen;
    logic [31:0] res;
    issue(1'b0, 32'h1234_5678, 5'd16);  // cycle 1
    step();
    step();                              // cycle 3
    reset = 1'b1;
    step();                              // cycle 4
    reset = 1'b0;
    checks++;
    if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", ctrl_busy); end
    checks++;
    if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL midrst_rdy: got %b want 0", data_resultRDY); end
    checks++;
    if (data_result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h want 00000000", data_result); end
    rdy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (data_resultRDY === 1'b1 || ctrl_busy === 1'b1) rdy_seen++;
      step();
    end
    checks++;
    if (rdy_seen != 0) begin errors++; $display("FAIL midrst_no_activity: got %0d active cycles want 0", rdy_seen); end
    issue(1'b0, 32'h1234_5678, 5'd16);
    wait_rdy(1, cyc, res, busy_cnt);
    checks++;
    if (cyc != 6) begin errors++; $display("FAIL midrst_restart_cycle: got %0d want 6", cyc); end
    checks++;
    if (res !== 32'h5678_0000) begin errors++; $display("FAIL midrst_restart_result: got %h want 56780000", res); end
    step();
  endtask

  // Every amount for both ops on a negative and a positive operand, back to back.
  task automatic test_amount_sweep();
    int cyc, busy_cnt;
    logic [31:0] res, exp;
    logic [31:0] ops[2];
    ops[0] = 32'h9ABC_DEF1;
    ops[1] = 32'h5ABC_DEF1;
    for (int o = 0; o < 2; o++) begin
      for (int op = 0; op < 2; op++) begin
        for (int amt = 0; amt < 32; amt++) begin
          if (op == 1) exp = $signed(ops[o]) >>> amt;
          else         exp = ops[o] << amt;
          issue(op[0], ops[o], amt[4:0]);
          wait_rdy(1, cyc, res, busy_cnt);
          checks++;
          if (cyc != 6 || res !== exp) begin
            errors++;
            $display("FAIL sweep a=%h op=%0d amt=%0d: got %h at cycle %0d want %h at cycle 6",
                     ops[o], op, amt, res, cyc, exp);
          end
        end
      end
    end
    step();
  endtask

  initial begin
    reset         = 1'b1;
    ctrl_start    = 1'b0;
    ctrl_op       = 1'b0;
    data_operandA = '0;
    ctrl_shiftamt = '0;
    #1;
    test_reset();
    test_basic_latency();
    test_vectors();
    test_back_to_back();
    test_reset_mid_shift();
    test_amount_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
